prime_search: RTL
=================

# prime_search

Self-contained prime candidate search controller, the parametrised successor to the bench-level loop that pairs `rand127` with `miller_rabin`. It assembles WORDSIZE-bit odd, full-width candidates from a free-running RAND_WIDTH-bit random stream. It launches each candidate into an external `miller_rabin` instance and retries until a prime is found or an attempt budget is spent. An optional divisible-by-3 prefilter discards cheap composites before they reach the tester.

## Interface
- `WORDSIZE`, 32: candidate width; must be a multiple of RAND_WIDTH.
- `RAND_WIDTH`, 16: random word width; must be even when the prefilter is compiled in.
- `CNT_W`, 16: attempt counter and budget width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `accuracy`  in  2*WORDSIZE  Miller-Rabin round count; latched on accepted start.
- `max_attempts`  in  CNT_W  attempt budget; latched on accepted start; 0 = unlimited.
- `rand_in`  in  RAND_WIDTH  random word; one word consumed per FILL cycle.
- `mr_start_number`  out  WORDSIZE  candidate to tester.
- `mr_accuracy`  out  2*WORDSIZE  latched accuracy.
- `mr_reset`  out  1  tester reset; low only in WAIT.
- `mr_finish`, `mr_prime`  in  1 each  tester result; sampled only in WAIT.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  last search ended with a prime.
- `prime_out`  out  WORDSIZE  found prime; 0 on failure.
- `attempts`  out  CNT_W  candidates completed in the current or last search.

## Operation
- NCHUNK = WORDSIZE/RAND_WIDTH. States: IDLE, FILL, LAUNCH, WAIT.
- IDLE: `start`=1 clears `attempts`, `found`, `prime_out`, latches `accuracy`/`max_attempts`, then goes to FILL.
- FILL: chunk k (k=0..NCHUNK-1, one per cycle) is written to candidate bits [(k+1)*RAND_WIDTH-1 -: RAND_WIDTH]. Bit 0 is forced to 1 in chunk 0. Bit WORDSIZE-1 is forced to 1 in the last chunk. Forcing is applied before the prefilter residue is accumulated.
- After the last chunk: if the prefilter rejects, `attempts`+1, then either budget exit or refill. Otherwise go to LAUNCH.
- LAUNCH: one cycle with `mr_start_number` stable and `mr_reset`=1, then WAIT.
- WAIT: `mr_reset`=0; wait for `mr_finish`=1 with no timeout. On finish, `attempts`+1.
  - `mr_prime`=1: IDLE, `found`=1, `prime_out`=candidate, `done` pulse.
  - `mr_prime`=0: refill via FILL, or budget exit.
- Budget exit: when `max_attempts`≠0 and the incremented `attempts` equals `max_attempts` with no prime, go to IDLE with `found`=0, `prime_out`=0, `done` pulse.
- `attempts` saturates at all-ones when `max_attempts`=0.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `mr_reset`=1, and all other outputs 0, including `mr_start_number` and `mr_accuracy`.
- Asynchronous reset at any point, including mid-WAIT, aborts the search immediately. No `done` pulse is produced.
- `start` at edge t: FILL occupies t+1..t+NCHUNK, LAUNCH is at t+NCHUNK+1, and `mr_reset` falls at t+NCHUNK+2.
- A prefilter reject returns to FILL on the next edge. A reject costs NCHUNK cycles; the tester is never released.
- `mr_finish` sampled high at edge f: `done`, `found`, `prime_out` and `attempts` update at f and `done` is high for exactly that cycle. `busy` falls at the same edge.
- `start` is accepted in the cycle after `done`.

## Configuration
- `PRIME_SEARCH_MOD3_EN` defined: a running residue r ← (r + chunk mod 3) mod 3 is kept during FILL, valid because 2^RAND_WIDTH ≡ 1 mod 3. r is reset at the start of each fill. The final r=0 rejects the candidate as described above.
- Macro undefined: there is no residue logic, and every filled candidate goes to LAUNCH.

## Structure
- Package `prime_pkg`: the state encoding, the NCHUNK derivation, and the `mod3_of_chunk` function.
- One sub-module, `prime_mod3_acc`: clear/accumulate residue register, instantiated only under the macro.

## Test plan
The bench models the tester by driving `mr_finish`/`mr_prime` directly. WORDSIZE=32, RAND_WIDTH=16.
- Reset held, then released: `mr_reset`=1, `busy`/`done`/`found`=0, `prime_out`=0, `attempts`=0.
- `rand_in` 0x0004 then 0x0000, then `mr_prime`=1 three cycles into WAIT: `mr_start_number`=0x80000005, `done` pulse, `found`=1, `prime_out`=0x80000005, `attempts`=1.
- `rand_in` 0x0000 then 0x0003, candidate 0x80030001:
  - with the macro: rejected, `mr_reset` stays 1, `attempts`=1, FILL restarts;
  - without the macro: LAUNCH occurs.
- `max_attempts`=2, tester returns composite twice: `done`, `found`=0, `prime_out`=0, `attempts`=2.
- `start` pulsed in WAIT is ignored. `reset` asserted mid-WAIT: IDLE immediately, `mr_reset`=1, `busy`=0, no `done`.
- `max_attempts`=0 with 5 composites then a prime: `attempts`=6, `found`=1.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared state encoding and residue helpers for the prime candidate search.
package prime_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_WAIT
  } state_t;

  function automatic int nchunk(input int wordsize, input int rand_width);
    return wordsize / rand_width;
  endfunction

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Even bit positions weigh 1 and odd ones weigh 2 modulo 3; chunks up to 64 bits.
  function automatic logic [1:0] mod3_of_chunk(input logic [63:0] chunk);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 64; i++) begin
      if (chunk[i]) r = add_mod3(r, (i % 2 == 0) ? 2'd1 : 2'd2);
    end
    return r;
  endfunction

endpackage

// File: rtl/prime_mod3_acc.sv
// Running mod-3 residue of the chunks written during one candidate fill.
module prime_mod3_acc
  import prime_pkg::*;
#(
  parameter int RAND_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_clear,
  input  logic [RAND_WIDTH-1:0] i_chunk,
  output logic [1:0]            o_res_next
);

  logic [1:0] r_res;
  logic [1:0] w_base;

  // The first chunk of a fill starts from zero rather than the stale residue.
  assign w_base     = i_clear ? 2'd0 : r_res;
  assign o_res_next = add_mod3(w_base, mod3_of_chunk(64'(i_chunk)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_res <= 2'd0;
    else if (i_en) r_res <= o_res_next;
  end

endmodule

// File: rtl/prime_search.sv
// Prime candidate search controller driving an external Miller-Rabin tester.
// Optional divisible-by-3 prefilter compiled in with PRIME_SEARCH_MOD3_EN.
module prime_search
  import prime_pkg::*;
#(
  parameter int WORDSIZE   = 32,
  parameter int RAND_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*WORDSIZE-1:0]   accuracy,
  input  logic [CNT_W-1:0]        max_attempts,
  input  logic [RAND_WIDTH-1:0]   rand_in,
  output logic [WORDSIZE-1:0]     mr_start_number,
  output logic [2*WORDSIZE-1:0]   mr_accuracy,
  output logic                    mr_reset,
  input  logic                    mr_finish,
  input  logic                    mr_prime,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [WORDSIZE-1:0]     prime_out,
  output logic [CNT_W-1:0]        attempts
);

  localparam int NCHUNK = nchunk(WORDSIZE, RAND_WIDTH);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [WORDSIZE-1:0]   r_cand;
  logic [2*WORDSIZE-1:0] r_acc;
  logic [CNT_W-1:0]      r_max;
  logic [CNT_W-1:0]      r_attempts;
  logic                  r_found;
  logic [WORDSIZE-1:0]   r_prime_out;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_mr_reset;

  logic                  w_last;
  logic [RAND_WIDTH-1:0] w_chunk;
  logic                  w_reject;
  logic [CNT_W-1:0]      w_att_inc;
  logic                  w_budget_hit;

  assign w_last = (r_idx == IDX_W'(NCHUNK - 1));

  // Odd and full-width forcing happens before the residue sees the chunk.
  always_comb begin
    w_chunk = rand_in;
    if (r_idx == '0) w_chunk[0] = 1'b1;
    if (w_last) w_chunk[RAND_WIDTH-1] = 1'b1;
  end

`ifdef PRIME_SEARCH_MOD3_EN
  logic [1:0] w_res_next;

  prime_mod3_acc #(
    .RAND_WIDTH(RAND_WIDTH)
  ) u_mod3 (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_state == S_FILL),
    .i_clear   (r_idx == '0),
    .i_chunk   (w_chunk),
    .o_res_next(w_res_next)
  );

  assign w_reject = (w_res_next == 2'd0);
`else
  assign w_reject = 1'b0;
`endif

  assign w_att_inc    = (&r_attempts) ? r_attempts : r_attempts + 1'b1;
  assign w_budget_hit = (r_max != '0) && (w_att_inc == r_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cand      <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_attempts  <= '0;
      r_found     <= 1'b0;
      r_prime_out <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_mr_reset  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_attempts  <= '0;
            r_found     <= 1'b0;
            r_prime_out <= '0;
            r_acc       <= accuracy;
            r_max       <= max_attempts;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          r_cand[r_idx*RAND_WIDTH +: RAND_WIDTH] <= w_chunk;
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_idx <= '0;
            if (w_reject) begin
              r_attempts <= w_att_inc;
              if (w_budget_hit) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_mr_reset <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mr_finish) begin
            r_attempts <= w_att_inc;
            r_mr_reset <= 1'b1;
            if (mr_prime) begin
              r_found     <= 1'b1;
              r_prime_out <= r_cand;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else if (w_budget_hit) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mr_start_number = r_cand;
  assign mr_accuracy     = r_acc;
  assign mr_reset        = r_mr_reset;
  assign busy            = r_busy;
  assign done            = r_done;
  assign found           = r_found;
  assign prime_out       = r_prime_out;
  assign attempts        = r_attempts;

endmodule
